// File: rtl/forward_exec_stage_pkg.sv
// ---------------------------------------------------------------------------
// forward_exec_stage_pkg
// Shared encodings for the execute/forwarding slice of the pipeline: opcode
// classes, ALU operation codes, operand-source (forwarding) select codes and
// the load/store opcodes. The decode/dependency block imports the same
// package, so both sides agree on every code point.
// ---------------------------------------------------------------------------
package forward_exec_stage_pkg;

    localparam int DATA_W = 8;
    localparam int REG_W  = 5;
    localparam int OP_W   = 5;

    // Instruction class is carried in Op_ex[4:3]
    typedef enum logic [1:0] {
        CLS_ALU_RR = 2'b00,
        CLS_ALU_RI = 2'b01,
        CLS_MEM    = 2'b10,
        CLS_JUMP   = 2'b11
    } op_class_e;

    // ALU operation is carried in Op_ex[2:0] for both ALU classes
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_NOT = 3'd5,
        ALU_SHL = 3'd6,
        ALU_SHR = 3'd7
    } alu_op_e;

    // Operand source selects produced by the dependency logic
    typedef enum logic [1:0] {
        SRC_RF  = 2'b00,
        SRC_EX  = 2'b01,
        SRC_MEM = 2'b10,
        SRC_WB  = 2'b11
    } src_sel_e;

    localparam logic [OP_W-1:0] OP_LOAD  = 5'b10100;
    localparam logic [OP_W-1:0] OP_STORE = 5'b10101;

    function automatic op_class_e op_class(input logic [OP_W-1:0] op);
        return op_class_e'(op[4:3]);
    endfunction

    function automatic logic is_alu(input logic [OP_W-1:0] op);
        return (op_class(op) == CLS_ALU_RR) || (op_class(op) == CLS_ALU_RI);
    endfunction

    function automatic logic is_load(input logic [OP_W-1:0] op);
        return op == OP_LOAD;
    endfunction

    function automatic logic is_load_store(input logic [OP_W-1:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    // Only ALU results and loaded data are written back to the register file
    function automatic logic writes_back(input logic [OP_W-1:0] op);
        return is_alu(op) || is_load(op);
    endfunction

endpackage

// File: rtl/exec_alu.sv
// ---------------------------------------------------------------------------
// exec_alu
// Purely combinational 8-bit ALU used by the execute stage. All arithmetic
// wraps; carries and shifted-out bits are discarded. Shifts are logical and
// use only the low three bits of operand b.
//
// Ports
//   a, b    in  8  operands (already forwarded / immediate-selected)
//   op      in  3  ALU operation code (alu_op_e)
//   result  out 8  operation result
//   zero    out 1  result == 0
// ---------------------------------------------------------------------------
module exec_alu
    import forward_exec_stage_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] op,
    output logic [7:0] result,
    output logic       zero
);

    alu_op_e op_e;

    assign op_e = alu_op_e'(op);

    always_comb begin
        result = '0;
        case (op_e)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_NOT: result = ~a;
            ALU_SHL: result = a << b[2:0];
            ALU_SHR: result = a >> b[2:0];
            default: result = '0;
        endcase
    end

    assign zero = (result == 8'h00);

endmodule

// File: rtl/forward_exec_stage.sv
// ---------------------------------------------------------------------------
// forward_exec_stage
// Execute stage with operand forwarding plus the EX, MEM and WB pipeline
// registers behind it. One instruction is accepted every cycle.
//
// Ports
//   Clkk, Rst                 clock (rising edge) / async active-high reset
//   Op_ex                     opcode of the instruction in EX
//   mux_sel_a, mux_sel_b      operand source: RF / EX / MEM / WB result
//   imm_sel, imm              replace operand B by zero-extended imm
//   mem_en_dec, mem_rw_dec,   decoder memory controls (enable, write,
//   mem_mux_sel_dec           take memory data into MEM stage)
//   RW_dec                    destination register number
//   rf_a, rf_b, mem_rdata     register-file and data-memory read data
//   mem_en, mem_rw,           data-memory request, driven from the EX
//   mem_addr, mem_wdata       register during the following cycle
//   wb_en, wb_addr, wb_data   register-file write port from the WB register
//   zero_flag                 registered "ALU result was zero"
// ---------------------------------------------------------------------------
module forward_exec_stage
    import forward_exec_stage_pkg::*;
(
    input  logic       Clkk,
    input  logic       Rst,
    input  logic [4:0] Op_ex,
    input  logic [1:0] mux_sel_a,
    input  logic [1:0] mux_sel_b,
    input  logic       imm_sel,
    input  logic [7:0] imm,
    input  logic       mem_en_dec,
    input  logic       mem_rw_dec,
    input  logic       mem_mux_sel_dec,
    input  logic [4:0] RW_dec,
    input  logic [7:0] rf_a,
    input  logic [7:0] rf_b,
    input  logic [7:0] mem_rdata,
    output logic       mem_en,
    output logic       mem_rw,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       wb_en,
    output logic [4:0] wb_addr,
    output logic [7:0] wb_data,
    output logic       zero_flag
);

    // EX register
    logic       ex_valid;
    logic       ex_we;
    logic       ex_mem_en;
    logic       ex_mem_rw;
    logic       ex_mem_sel;
    logic [7:0] ex_res;
    logic [4:0] ex_dst;
    logic [7:0] ex_sdata;

    // MEM register
    logic       mem_valid;
    logic       mem_we;
    logic [7:0] mem_res;
    logic [4:0] mem_dst;

    // WB register
    logic       wb_we;
    logic [7:0] wb_res;
    logic [4:0] wb_dst;

    logic       zero_q;

    // Decode of the incoming opcode
    logic       inst_alu;
    logic       inst_ldst;
    logic       inst_valid;

    logic [7:0] opnd_a;
    logic [7:0] opnd_b_fwd;
    logic [7:0] opnd_b;
    logic [7:0] alu_res;
    logic       alu_zero;
    logic [7:0] ex_next;

    // Memory NOPs and jumps carry no data through the pipe, so the data
    // registers keep their previous contents while they pass.
    assign inst_alu   = is_alu(Op_ex);
    assign inst_ldst  = is_load_store(Op_ex);
    assign inst_valid = inst_alu || inst_ldst;

    // Forwarding picks stage data regardless of that stage's write-enable
    always_comb begin
        opnd_a = rf_a;
        case (src_sel_e'(mux_sel_a))
            SRC_RF:  opnd_a = rf_a;
            SRC_EX:  opnd_a = ex_res;
            SRC_MEM: opnd_a = mem_res;
            SRC_WB:  opnd_a = wb_res;
            default: opnd_a = rf_a;
        endcase
    end

    always_comb begin
        opnd_b_fwd = rf_b;
        case (src_sel_e'(mux_sel_b))
            SRC_RF:  opnd_b_fwd = rf_b;
            SRC_EX:  opnd_b_fwd = ex_res;
            SRC_MEM: opnd_b_fwd = mem_res;
            SRC_WB:  opnd_b_fwd = wb_res;
            default: opnd_b_fwd = rf_b;
        endcase
    end

    // Store data is the forwarded B operand, taken before the immediate
    // replaces it as the address offset.
    assign opnd_b = imm_sel ? imm : opnd_b_fwd;

    exec_alu u_alu (
        .a      (opnd_a),
        .b      (opnd_b),
        .op     (Op_ex[2:0]),
        .result (alu_res),
        .zero   (alu_zero)
    );

    assign ex_next = inst_alu ? alu_res : (opnd_a + opnd_b);

    // EX register: memory controls are gated here so a stray decoder bit on
    // a non load/store opcode can never reach the memory port.
    always_ff @(posedge Clkk or posedge Rst) begin
        if (Rst) begin
            ex_valid   <= 1'b0;
            ex_we      <= 1'b0;
            ex_mem_en  <= 1'b0;
            ex_mem_rw  <= 1'b0;
            ex_mem_sel <= 1'b0;
            ex_res     <= '0;
            ex_dst     <= '0;
            ex_sdata   <= '0;
            zero_q     <= 1'b0;
        end else begin
            ex_valid   <= inst_valid;
            ex_we      <= writes_back(Op_ex);
            ex_mem_en  <= mem_en_dec && inst_ldst;
            ex_mem_rw  <= mem_rw_dec && inst_ldst;
            ex_mem_sel <= mem_mux_sel_dec && inst_ldst;
            if (inst_valid) begin
                ex_res   <= ex_next;
                ex_dst   <= RW_dec;
                ex_sdata <= opnd_b_fwd;
            end
            if (inst_alu) begin
                zero_q <= alu_zero;
            end
        end
    end

    // MEM register: loads take the memory read data, everything else the
    // EX result (for stores that is the address).
    always_ff @(posedge Clkk or posedge Rst) begin
        if (Rst) begin
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_res   <= '0;
            mem_dst   <= '0;
        end else begin
            mem_valid <= ex_valid;
            mem_we    <= ex_we;
            if (ex_valid) begin
                mem_res <= ex_mem_sel ? mem_rdata : ex_res;
                mem_dst <= ex_dst;
            end
        end
    end

    // WB register feeding the register-file write port
    always_ff @(posedge Clkk or posedge Rst) begin
        if (Rst) begin
            wb_we  <= 1'b0;
            wb_res <= '0;
            wb_dst <= '0;
        end else begin
            wb_we <= mem_we;
            if (mem_valid) begin
                wb_res <= mem_res;
                wb_dst <= mem_dst;
            end
        end
    end

    assign mem_en    = ex_mem_en;
    assign mem_rw    = ex_mem_rw;
    assign mem_addr  = ex_res;
    assign mem_wdata = ex_sdata;
    assign wb_en     = wb_we;
    assign wb_addr   = wb_dst;
    assign wb_data   = wb_res;
    assign zero_flag = zero_q;

endmodule

// File: doc/forward_exec_stage.md
FORWARD_EXEC_STAGE -- requirements
Module: forward_exec_stage

Interface
REQ-001 SHALL provide: Clkk  in  1  single processor clock, all state on rising edge.
REQ-002 SHALL provide: Rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL provide: Op_ex  in  5  opcode of the instruction entering EX.
REQ-004 SHALL provide: mux_sel_a, mux_sel_b  in  2 each  operand source: 00 register file, 01 EX result, 10 MEM result, 11 WB result.
REQ-005 SHALL provide: imm_sel  in  1  select imm as operand B; imm  in  8  zero-extended immediate.
REQ-006 SHALL provide: mem_en_dec, mem_rw_dec (1 write), mem_mux_sel_dec (1 take memory data)  in  1 each.
REQ-007 SHALL provide: RW_dec  in  5  destination register number.
REQ-008 SHALL provide: rf_a, rf_b  in  8  register-file read data; mem_rdata  in  8  data-memory read data, valid in the same cycle as the request.
REQ-009 SHALL provide: mem_en, mem_rw  out  1 each; mem_addr, mem_wdata  out  8 each.
REQ-010 SHALL provide: wb_en  out  1; wb_addr  out  5; wb_data  out  8; zero_flag  out  1.

Function
REQ-011 Operand A SHALL be rf_a, ex_res, mem_res or wb_res for mux_sel_a 00/01/10/11; operand B likewise for mux_sel_b, then replaced by imm when imm_sel=1.
REQ-012 Classes by Op_ex[4:3]: 00 ALU reg-reg, 01 ALU reg-imm, 10 memory (10100 load, 10101 store, others NOP), 11 jump/branch (no writeback).
REQ-013 ALU op by Op_ex[2:0] for classes 00/01: ADD, SUB, AND, OR, XOR, NOT A, A shl B[2:0], A shr B[2:0] (logical); all 8-bit, wrap-around, carry discarded.
REQ-014 For loads/stores the EX result SHALL be A+B (address); store data SHALL be operand B.
REQ-015 Edge N (inputs valid in cycle N): EX register captures result, RW_dec, write-enable, mem_en_dec, mem_rw_dec, mem_mux_sel_dec, store data.
REQ-016 Cycle N+1: mem_en/mem_rw/mem_addr/mem_wdata SHALL be driven combinationally from the EX register; edge N+1: MEM register captures mem_rdata if mem_mux_sel=1 else ex_res.
REQ-017 Edge N+2: WB register captures MEM stage; wb_en/wb_addr/wb_data driven from it in cycle N+2.
REQ-018 Write-enable SHALL be 1 for classes 00, 01 and load; 0 otherwise; register 0 is writable.
REQ-019 zero_flag SHALL register (ALU result == 0) at each edge for classes 00/01, hold otherwise.
REQ-020 Forwarding SHALL use stage data regardless of stage write-enable; data-stage registers hold value when no instruction (NOP) passes.
REQ-021 mem_en and mem_rw SHALL never assert in a cycle whose EX-stage opcode is not load/store, even if decoder bits say so.
REQ-022 No stall or flush input: one instruction accepted per cycle, unconditionally.

Reset
REQ-023 Rst=1 SHALL immediately clear all stage registers: results 0, addresses 0, enables 0, zero_flag 0.
REQ-024 Reset mid-operation SHALL drop all in-flight instructions; first instruction after release behaves as after power-up.

Structure
REQ-025 Opcode encodings, class codes, ALU op codes and mux-select codes SHALL live in a shared package used also by the decode/dependency block.
REQ-026 The ALU SHALL be a separate sub-module exec_alu (operands, op, result, zero); pipeline registers stay in forward_exec_stage.

Verification
REQ-027 Reset: assert Rst mid-stream -> wb_en, mem_en, zero_flag 0 same cycle; wb_data 0.
REQ-028 ADD rf_a=8'h0F, rf_b=8'h01, sel 00/00, RW_dec=3 -> two cycles later wb_en=1, wb_addr=3, wb_data=8'h10.
REQ-029 Back-to-back: ADD -> 8'h10, next SUB with mux_sel_a=01, rf_b=8'h10 -> wb_data=8'h00, zero_flag=1 after SUB edge.
REQ-030 Store 10101, A=8'h20, imm_sel=1, imm=8'h04, rf_b=8'hAA -> next cycle mem_en=1, mem_rw=1, mem_addr=8'h24, mem_wdata=8'hAA; wb_en stays 0.
REQ-031 Load 10100, addr 8'h24, mem_rdata=8'hAA, mem_mux_sel_dec=1, RW_dec=5 -> mem_en=1, mem_rw=0, then wb_data=8'hAA, wb_addr=5; following instruction with mux_sel_a=11 sees 8'hAA.
REQ-032 Overflow/shift: ADD 8'hFF+8'h02 -> 8'h01; shl 8'h81 by 1 -> 8'h02; jump 11000 with mem_en_dec=1 -> mem_en 0, wb_en 0.
